// File: rtl/clk_freq_meter_pkg.sv
// Shared types and helpers for the gated frequency meter.
// The optional period tracking is enabled with FREQ_METER_PERIOD_EN.
package clk_freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_GATE_W = 16;

    // Callers zero-extend into 32 bits and truncate the result back to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        if (val >= max_val) begin
            return max_val;
        end
        return val + 32'd1;
    endfunction

endpackage

// File: rtl/edge_period_tracker.sv
// Edge-to-edge period counter with running min/max, used by clk_freq_meter
// only when FREQ_METER_PERIOD_EN is defined.
module edge_period_tracker
    import clk_freq_meter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             sample,
    input  logic             rise,
    output logic [CNT_W-1:0] min_next,
    output logic [CNT_W-1:0] max_next
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             armed;
    logic             have_period;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] min_r;
    logic [CNT_W-1:0] max_r;
    logic             period_hit;

    assign period_hit = sample && rise && armed;

    // Values as they stand after this cycle; 0 until two edges have been seen.
    always_comb begin
        min_next = min_r;
        max_next = max_r;
        if (have_period) begin
            if (period_hit && (per_cnt < min_r)) begin
                min_next = per_cnt;
            end
            if (period_hit && (per_cnt > max_r)) begin
                max_next = per_cnt;
            end
        end else if (period_hit) begin
            min_next = per_cnt;
            max_next = per_cnt;
        end else begin
            min_next = '0;
            max_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed       <= 1'b0;
            have_period <= 1'b0;
            per_cnt     <= '0;
            min_r       <= '0;
            max_r       <= '0;
        end else if (clear) begin
            armed       <= 1'b0;
            have_period <= 1'b0;
            per_cnt     <= '0;
            min_r       <= '0;
            max_r       <= '0;
        end else if (sample) begin
            if (rise) begin
                armed   <= 1'b1;
                per_cnt <= CNT_W'(1);
                if (armed) begin
                    have_period <= 1'b1;
                    min_r       <= min_next;
                    max_r       <= max_next;
                end
            end else if (armed) begin
                per_cnt <= CNT_W'(sat_inc(32'(per_cnt), 32'(CNT_MAX)));
            end
        end
    end

endmodule

// File: rtl/clk_freq_meter.sv
// Gated frequency meter: counts rising edges of a same-domain divided clock over
// a programmable window. Period min/max tracking is built only with FREQ_METER_PERIOD_EN.
module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int GATE_W = DEF_GATE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_len,
    input  logic              clk_div_in,
    input  logic [CNT_W-1:0]  exp_min,
    input  logic [CNT_W-1:0]  exp_max,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  edge_cnt,
    output logic [CNT_W-1:0]  min_period,
    output logic [CNT_W-1:0]  max_period,
    output logic              in_range
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            next_state;
    logic              prev;
    logic              rise;
    logic              accept;
    logic              sample;
    logic              load;
    logic              busy_next;
    logic              done_next;
    logic [GATE_W-1:0] remain;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [CNT_W-1:0]  lat_min;
    logic [CNT_W-1:0]  lat_max;

    assign rise     = clk_div_in & ~prev;
    assign accept   = (state == IDLE) && start;
    assign sample   = (state == RUN);
    assign cnt_next = rise ? CNT_W'(sat_inc(32'(cnt), 32'(CNT_MAX))) : cnt;

    // prev runs in every state so an edge on the first RUN cycle is seen correctly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= clk_div_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (remain == '0) next_state = REPORT;
            REPORT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Decoded from next_state so busy/done can be registered without a cycle of lag.
    always_comb begin
        busy_next = (next_state != IDLE);
        done_next = (next_state == REPORT);
        load      = (state == RUN) && (next_state == REPORT);
    end

    // remain holds cycles left after the current one; a zero gate behaves as one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain  <= '0;
            cnt     <= '0;
            lat_min <= '0;
            lat_max <= '0;
        end else if (accept) begin
            remain  <= (gate_len == '0) ? '0 : gate_len - GATE_W'(1);
            cnt     <= '0;
            lat_min <= exp_min;
            lat_max <= exp_max;
        end else if (sample) begin
            cnt <= cnt_next;
            if (remain != '0) begin
                remain <= remain - GATE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            edge_cnt <= '0;
            in_range <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
            if (load) begin
                edge_cnt <= cnt_next;
                in_range <= (cnt_next >= lat_min) && (cnt_next <= lat_max);
            end
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    logic [CNT_W-1:0] min_next;
    logic [CNT_W-1:0] max_next;

    edge_period_tracker #(
        .CNT_W (CNT_W)
    ) u_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .sample   (sample),
        .rise     (rise),
        .min_next (min_next),
        .max_next (max_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_period <= '0;
            max_period <= '0;
        end else if (load) begin
            min_period <= min_next;
            max_period <= max_next;
        end
    end
`else
    assign min_period = '0;
    assign max_period = '0;
`endif

endmodule

// File: tb/tb_clk_freq_meter.sv
// Scoreboard bench for clk_freq_meter; period expectations follow FREQ_METER_PERIOD_EN.
module tb_clk_freq_meter;

    typedef struct {
        logic [15:0] cnt;
        logic [15:0] minp;
        logic [15:0] maxp;
        logic        inr;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start4;
    logic [15:0] gate_len;
    logic        clk_div_in;
    logic [15:0] exp_min;
    logic [15:0] exp_max;
    logic [3:0]  exp_min4;
    logic [3:0]  exp_max4;
    logic        busy;
    logic        done;
    logic [15:0] edge_cnt;
    logic [15:0] min_period;
    logic [15:0] max_period;
    logic        in_range;
    logic        busy4;
    logic        done4;
    logic [3:0]  edge_cnt4;
    logic [3:0]  min_period4;
    logic [3:0]  max_period4;
    logic        in_range4;

    int   cyc;
    int   vectors;
    int   miscompares;
    exp_t sb[$];
    exp_t sb4[$];

    clk_freq_meter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .gate_len   (gate_len),
        .clk_div_in (clk_div_in),
        .exp_min    (exp_min),
        .exp_max    (exp_max),
        .busy       (busy),
        .done       (done),
        .edge_cnt   (edge_cnt),
        .min_period (min_period),
        .max_period (max_period),
        .in_range   (in_range)
    );

    clk_freq_meter #(
        .CNT_W  (4),
        .GATE_W (16)
    ) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .gate_len   (gate_len),
        .clk_div_in (clk_div_in),
        .exp_min    (exp_min4),
        .exp_max    (exp_max4),
        .busy       (busy4),
        .done       (done4),
        .edge_cnt   (edge_cnt4),
        .min_period (min_period4),
        .max_period (max_period4),
        .in_range   (in_range4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int pe(input int v);
`ifdef FREQ_METER_PERIOD_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic logic pat(input int kind, input int i);
        case (kind)
            0:       return (i % 2) == 0;
            1:       return (i % 7) < 4;
            2:       return ((i % 5) == 0) || ((i % 5) == 2);
            3:       return 1'b1;
            5:       return i == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("done_cycle", 32'(cyc), 32'(e.cyc));
                checkOutput("edge_cnt", 32'(edge_cnt), 32'(e.cnt));
                checkOutput("min_period", 32'(min_period), 32'(e.minp));
                checkOutput("max_period", 32'(max_period), 32'(e.maxp));
                checkOutput("in_range", 32'(in_range), 32'(e.inr));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (sb4.size() == 0) begin
                checkOutput("unexpected_done4", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb4.pop_front();
                checkOutput("done_cycle4", 32'(cyc), 32'(e.cyc));
                checkOutput("edge_cnt4", 32'(edge_cnt4), 32'(e.cnt));
                checkOutput("min_period4", 32'(min_period4), 32'(e.minp));
                checkOutput("max_period4", 32'(max_period4), 32'(e.maxp));
                checkOutput("in_range4", 32'(in_range4), 32'(e.inr));
            end
        end
    end

    task automatic applyStimulus(input bit use4, input int g, input int kind, input bit pre,
                                 input int emin, input int emax, input int ecnt,
                                 input int eminp, input int emaxp, input bit einr,
                                 input bit mid_start);
        int   geff;
        exp_t e;
        geff = (g == 0) ? 1 : g;
        @(negedge clk);
        clk_div_in = pre;
        gate_len   = 16'(g);
        exp_min    = 16'(emin);
        exp_max    = 16'(emax);
        exp_min4   = 4'(emin);
        exp_max4   = 4'(emax);
        e.cnt  = 16'(ecnt);
        e.minp = 16'(pe(eminp));
        e.maxp = 16'(pe(emaxp));
        e.inr  = einr;
        e.cyc  = cyc + geff + 1;
        if (use4) begin
            start4 = 1'b1;
            sb4.push_back(e);
        end else begin
            start = 1'b1;
            sb.push_back(e);
        end
        for (int i = 0; i < geff; i++) begin
            @(negedge clk);
            start      = mid_start && (i == 3);
            start4     = 1'b0;
            clk_div_in = pat(kind, i);
            if (i == 0) begin
                checkOutput("busy_first_run", 32'(use4 ? busy4 : busy), 32'd1);
            end
        end
        @(negedge clk);
        start      = 1'b0;
        clk_div_in = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_done", 32'(use4 ? busy4 : busy), 32'd0);
        checkOutput("done_seen", 32'(use4 ? sb4.size() : sb.size()), 32'd0);
        sb.delete();
        sb4.delete();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cyc = 0; vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = 1'b0; start4 = 1'b0; gate_len = '0;
        clk_div_in = 1'b0; exp_min = '0; exp_max = '0; exp_min4 = '0; exp_max4 = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        checkOutput("rst_in_range", 32'(in_range), 32'd0);
        checkOutput("rst_min_period", 32'(min_period), 32'd0);
        checkOutput("rst_max_period", 32'(max_period), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // use4 g kind pre emin emax cnt minp maxp inr mid_start
        applyStimulus(0, 10, 0, 0, 0, 100, 5, 2, 2, 1, 0);
        repeat (3) @(negedge clk);
        checkOutput("hold_edge_cnt", 32'(edge_cnt), 32'd5);
        applyStimulus(0, 70, 1, 0, 10, 10, 10, 7, 7, 1, 0);
        applyStimulus(0, 50, 2, 0, 18, 22, 20, 2, 3, 1, 0);
        applyStimulus(0, 20, 3, 1, 1, 100, 0, 0, 0, 0, 0);
        applyStimulus(1, 64, 0, 0, 0, 15, 15, 2, 2, 1, 0);
        applyStimulus(0, 10, 4, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 5, 0, 2, 5, 1, 0, 0, 0, 0);
        applyStimulus(0, 10, 0, 0, 0, 4, 5, 2, 2, 0, 0);

        // Reset in the middle of a window: no done, everything back to 0.
        @(negedge clk);
        gate_len = 16'd30;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            clk_div_in = ~clk_div_in;
        end
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_edge_cnt", 32'(edge_cnt), 32'd0);
        checkOutput("abort_in_range", 32'(in_range), 32'd0);
        @(negedge clk);
        clk_div_in = 1'b0;
        rst_n      = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("abort_idle_busy", 32'(busy), 32'd0);

        applyStimulus(0, 10, 0, 0, 0, 100, 5, 2, 2, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_freq_meter.md
# clk_freq_meter

Gated frequency meter that sits directly downstream of the team's clock dividers (integer and fractional). It samples a divided-clock signal generated in the same `clk` domain and counts its rising edges over a programmable window of reference cycles. With the period feature enabled, it also records the shortest and longest edge-to-edge period seen. A range check flags divider outputs whose edge count falls outside an expected band, so the block serves as both a built-in self-check and a bench monitor.

## Interface
Parameters:
- `CNT_W`, 16, width of edge count and period counters
- `GATE_W`, 16, width of gate length

Ports:
- `clk` in 1: reference clock; the divider under measurement runs from this same clock
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: request a measurement; honoured only in IDLE
- `gate_len` in GATE_W: window length in `clk` cycles; latched on accepted `start`
- `clk_div_in` in 1: divided clock, synchronous to `clk`, treated as data
- `exp_min` in CNT_W: lower bound of the acceptable edge count, inclusive; latched with `gate_len`
- `exp_max` in CNT_W: upper bound of the acceptable edge count, inclusive; latched with `gate_len`
- `busy` out 1: measurement in progress
- `done` out 1: one-cycle pulse; results valid
- `edge_cnt` out CNT_W: rising edges counted in the window
- `min_period` out CNT_W: shortest edge-to-edge period, in cycles
- `max_period` out CNT_W: longest edge-to-edge period, in cycles
- `in_range` out 1: `exp_min <= edge_cnt <= exp_max`

## Operation
- Edge detection:
  - `prev` register samples `clk_div_in` every cycle, including in IDLE; reset value 0.
  - A rising edge is `clk_div_in & ~prev`.
- FSM states: IDLE, RUN, REPORT.
  - IDLE → RUN on `start`. At that point `gate_len`, `exp_min` and `exp_max` are latched; a `gate_len` of 0 is treated as 1.
  - RUN lasts exactly the latched gate length in cycles, then → REPORT.
  - REPORT lasts one cycle: result registers are loaded, `done` is asserted, then → IDLE.
- Edge counting:
  - Counts rising edges seen during RUN cycles only.
  - Saturates at 2^CNT_W−1.
- Period measurement:
  - The first edge in the window arms a period counter.
  - Each later edge compares the counter value (cycles since the previous edge) against the running min/max, then restarts the counter at 1.
  - The period counter saturates.
  - With fewer than 2 edges in the window, `min_period` and `max_period` report 0.
- `start` is ignored while in RUN or REPORT; no queuing.
- Outputs are all registered. `edge_cnt`, `min_period`, `max_period` and `in_range` hold their last result until the next REPORT.
- Reset values: every output is 0. Reset asserted mid-RUN aborts the measurement: the FSM returns to IDLE and no `done` is produced.

## Timing
- An accepted `start` in cycle t gives:
  - `busy` = 1 in cycles t+1 .. t+G+1, where G is the latched gate length.
  - RUN samples cycles t+1 .. t+G.
  - `done` = 1 in cycle t+G+1 only, with results valid in that same cycle.
  - `busy` = 0 from cycle t+G+2.
- Earliest next accepted `start` is cycle t+G+2.
- An edge on the first RUN cycle counts if `prev` was 0 in the preceding IDLE cycle.

## Configuration
- `FREQ_METER_PERIOD_EN`:
  - Defined: period counter and min/max tracking are built as described above.
  - Undefined: that logic is absent; `min_period` and `max_period` are tied to 0. Edge counting and the range check are unchanged.

## Structure
- Shared package holds:
  - FSM state enum (IDLE/RUN/REPORT)
  - Saturating-increment helper function
  - Default `CNT_W`/`GATE_W` constants
- One sub-module, `edge_period_tracker`, contains the period counter and min/max registers; it is instantiated only under `FREQ_METER_PERIOD_EN`.

## Test plan
- `clk_div_in` toggling 1,0,1,0… starting on the first RUN cycle, `gate_len`=10 → `edge_cnt`=5, `min_period`=`max_period`=2, `done` at t+11.
- Repeating 7-cycle pattern with 4 high and 3 low, first high on the first RUN cycle, `gate_len`=70 → `edge_cnt`=10, `min_period`=`max_period`=7.
- Alternating periods 2 and 3 (pattern 1,0,1,0,0 repeated, first 1 on the first RUN cycle), `gate_len`=50 → `edge_cnt`=20, `min_period`=2, `max_period`=3; `exp_min`=18, `exp_max`=22 → `in_range`=1.
- `clk_div_in` held high from before `start`, `gate_len`=20, `exp_min`=1 → `edge_cnt`=0, periods 0, `in_range`=0.
- `CNT_W`=4, toggling input, `gate_len`=64 → `edge_cnt`=15 (saturated).
- `start` pulsed during RUN → ignored, single `done`; `rst_n` low mid-RUN → `busy`=0, all outputs 0, no `done`.
